gpio_cfg_encoder_axis32: RTL
============================

# gpio_cfg_encoder_axis32

Command encoder that drives the 32-bit AXI-Stream tone-configuration command channel consumed by the GPIO config decoder. Accepts per-tone configuration requests (index, gain, commit) and asynchronous SAFE updates from the host-side control logic. Serializes them into one-command-per-beat words with full `tready` backpressure support. Sits between the PS/register front-end and the stream input of the tone-table decoder.

## Interface
Parameters:
- IDX_W, 10, width of tone index payload (1..20)
- GAIN_W, 18, width of gain payload, Q1.17 (1..20)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  configuration request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_ch  in  1  channel, 0=A, 1=B
- req_tone  in  3  tone 0..7
- req_index  in  IDX_W  index payload
- req_gain  in  GAIN_W  gain payload
- req_send_idx  in  1  emit INDEX word
- req_send_gain  in  1  emit GAIN word
- req_commit  in  1  emit COMMIT word after the others
- safe_req  in  1  one-cycle SAFE update request
- safe_val  in  1  SAFE value sampled with safe_req
- m_axis_tdata  out  32  command word
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  sink ready
- busy  out  1  high whenever state != IDLE or SAFE pending
- word_cnt  out  16  count of completed handshakes, wraps 0xFFFF->0

## Operation
- Word format: [31:28] CMD (1=INDEX, 2=GAIN, C=SAFE, F=COMMIT), [27] CH, [26:24] TONE, [23:20] 0, [19:0] DATA, zero-extended.
- INDEX: DATA = req_index. GAIN: DATA = req_gain. SAFE: DATA[0] = safe_val, CH/TONE/other DATA bits 0. COMMIT: bits [27:0] all 0.
- Request fields are captured into holding registers on accept. Inputs may change afterwards.
- SAFE path: safe_req sets a one-entry pending flag and stores safe_val. A new safe_req while pending overwrites the stored value (last wins). No second word is produced.
- States: IDLE, S_IDX, S_GAIN, S_COMMIT, S_SAFE.
- In IDLE, SAFE pending has priority: go to S_SAFE and do not accept a request.
- Otherwise, on request accept, go to the first enabled state in order IDX -> GAIN -> COMMIT.
- If no flags are set, the request is accepted, discarded, and the state stays IDLE.
- On handshake (tvalid & tready), advance to the next enabled state. After the last word, return to IDLE.
- On S_SAFE handshake, clear the pending flag and return to IDLE.
- safe_req arriving mid-burst is held pending. It is sent after the burst, before any new request.
- safe_req in the same cycle as the S_SAFE handshake leaves the flag set with the new value; the second SAFE word is then sent.
- req_ready = (state == IDLE) & ~safe_pending. This is combinational from registers only, never from m_axis_tready.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, state=IDLE, safe pending=0, word_cnt=0, busy=0. req_ready=1 in the first cycle after rst deasserts.
- m_axis_tdata and m_axis_tvalid are registered.
- Request accepted at edge N: first word has tvalid=1 in cycle N+1.
- tdata is stable while tvalid=1 and tready=0. tvalid never drops without a handshake, except on reset.
- Back-to-back words: on a handshake edge the next word is loaded, so tvalid stays high with no bubble. A 3-word burst with tready=1 takes 3 cycles.
- After the last handshake, tvalid=0 and req_ready=1 in the next cycle.
- Minimum request period is words+1 cycles.
- SAFE latency from IDLE: safe_req at edge N gives tvalid in cycle N+2 (flag set at N, word loaded at N+1).
- word_cnt increments at each handshake edge.
- rst mid-burst: all state, including the pending SAFE and remaining words, is dropped. tvalid=0 in the next cycle.

## Test plan
- Full request: ch=1, tone=5, index=0x3FF, gain=0x20000, all flags set, tready=1 -> words 0x1D0003FF, 0x2D020000, 0xF0000000 on consecutive cycles; word_cnt=3; req_ready high again one cycle later.
- Backpressure: same request with tready toggling randomly -> identical word sequence; tdata stable while stalled; no duplicated or lost words.
- SAFE during burst: safe_req (val=1) pulses during the GAIN word, and a new request is waiting -> after COMMIT, 0xC0000001 is sent before the next request is accepted.
- SAFE overwrite: safe_req val=1 then val=0 while stalled -> exactly one SAFE word, 0xC0000000.
- Edge cases: request with all flags 0 -> accepted, no tvalid. Gain-only request, ch=0, tone=0, gain=0x1 -> single word 0x20000001.
- Reset mid-burst during a stalled GAIN word -> tvalid=0 next cycle, word_cnt=0, req_ready=1, pending SAFE cleared.

Source files
------------

// File: rtl/gpio_cfg_encoder_axis32.sv
// Tone-configuration command encoder: serializes INDEX/GAIN/COMMIT requests and
// SAFE updates into one 32-bit AXI-Stream command word per beat.
module gpio_cfg_encoder_axis32 #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned GAIN_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ch,
  input  logic [2:0]        req_tone,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [GAIN_W-1:0] req_gain,
  input  logic              req_send_idx,
  input  logic              req_send_gain,
  input  logic              req_commit,
  input  logic              safe_req,
  input  logic              safe_val,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int unsigned DATA_W = 20;
  localparam logic [3:0] CMD_INDEX  = 4'h1;
  localparam logic [3:0] CMD_GAIN   = 4'h2;
  localparam logic [3:0] CMD_SAFE   = 4'hC;
  localparam logic [3:0] CMD_COMMIT = 4'hF;

  typedef enum logic [2:0] {IDLE, S_IDX, S_GAIN, S_COMMIT, S_SAFE} state_t;

  state_t state, state_nxt;

  logic              h_ch;
  logic [2:0]        h_tone;
  logic [IDX_W-1:0]  h_index;
  logic [GAIN_W-1:0] h_gain;
  logic              h_send_gain;
  logic              h_commit;
  logic              safe_pending, pend_nxt;
  logic              safe_val_q, sval_nxt;
  logic [31:0]       tdata_nxt;
  logic              hs;
  logic              accept;
  logic              load;

  // Word fields come from the live request when leaving IDLE, else from holds
  logic              src_ch;
  logic [2:0]        src_tone;
  logic [IDX_W-1:0]  src_index;
  logic [GAIN_W-1:0] src_gain;
  logic              src_send_gain;
  logic              src_commit;

  // Next-state, SAFE flag and next command word
  always_comb begin
    state_nxt     = state;
    pend_nxt      = safe_pending;
    sval_nxt      = safe_val_q;
    tdata_nxt     = m_axis_tdata;
    accept        = 1'b0;
    hs            = m_axis_tvalid & m_axis_tready;
    src_ch        = h_ch;
    src_tone      = h_tone;
    src_index     = h_index;
    src_gain      = h_gain;
    src_send_gain = h_send_gain;
    src_commit    = h_commit;

    case (state)
      IDLE: begin
        if (safe_pending) begin
          state_nxt = S_SAFE;
        end else if (req_valid) begin
          accept        = 1'b1;
          src_ch        = req_ch;
          src_tone      = req_tone;
          src_index     = req_index;
          src_gain      = req_gain;
          src_send_gain = req_send_gain;
          src_commit    = req_commit;
          if (req_send_idx)       state_nxt = S_IDX;
          else if (req_send_gain) state_nxt = S_GAIN;
          else if (req_commit)    state_nxt = S_COMMIT;
          else                    state_nxt = IDLE;
        end
      end
      S_IDX: begin
        if (hs) begin
          if (src_send_gain)   state_nxt = S_GAIN;
          else if (src_commit) state_nxt = S_COMMIT;
          else                 state_nxt = IDLE;
        end
      end
      S_GAIN: begin
        if (hs) state_nxt = src_commit ? S_COMMIT : IDLE;
      end
      S_COMMIT: begin
        if (hs) state_nxt = IDLE;
      end
      S_SAFE: begin
        if (hs) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A fresh SAFE request always wins, even on the cycle its predecessor drains
    if (safe_req) begin
      pend_nxt = 1'b1;
      sval_nxt = safe_val;
    end

    load = (state_nxt != state) && (state_nxt != IDLE);
    if (load) begin
      case (state_nxt)
        S_IDX:    tdata_nxt = {CMD_INDEX, src_ch, src_tone, 4'h0, DATA_W'(src_index)};
        S_GAIN:   tdata_nxt = {CMD_GAIN, src_ch, src_tone, 4'h0, DATA_W'(src_gain)};
        S_COMMIT: tdata_nxt = {CMD_COMMIT, 28'd0};
        S_SAFE:   tdata_nxt = {CMD_SAFE, 27'd0, sval_nxt};
        default:  tdata_nxt = m_axis_tdata;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      h_ch          <= 1'b0;
      h_tone        <= 3'd0;
      h_index       <= '0;
      h_gain        <= '0;
      h_send_gain   <= 1'b0;
      h_commit      <= 1'b0;
      safe_pending  <= 1'b0;
      safe_val_q    <= 1'b0;
      m_axis_tdata  <= 32'd0;
      m_axis_tvalid <= 1'b0;
      word_cnt      <= 16'd0;
      busy          <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      if (accept) begin
        h_ch        <= req_ch;
        h_tone      <= req_tone;
        h_index     <= req_index;
        h_gain      <= req_gain;
        h_send_gain <= req_send_gain;
        h_commit    <= req_commit;
      end
      safe_pending  <= pend_nxt;
      safe_val_q    <= sval_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= (state_nxt != IDLE);
      if (hs) word_cnt <= word_cnt + 16'd1;
      busy          <= (state_nxt != IDLE) | pend_nxt;
      req_ready     <= (state_nxt == IDLE) & ~pend_nxt;
    end
  end

endmodule
